// File: rtl/neopixel_rx.sv
// NeoPixel (WS2812-style) single-wire receiver: decodes pulse-width bits into pixel words and writes them over Avalon-MM.
// Optional macro NEOPIXEL_RX_FORWARD_EN regenerates the serial stream on oDOUT while passing surplus pixels downstream.
module neopixel_rx #(
    parameter int unsigned pFIFO_DEPTH    = 8,
    parameter logic [31:0] pSTART_ADDRESS = 32'h0
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic [3:0]  iCSR_ADDRESS,
    input  logic        iCSR_READ,
    output logic [31:0] oCSR_READ_DATA,
    input  logic        iCSR_WRITE,
    input  logic [31:0] iCSR_WRITE_DATA,
    output logic [31:0] oDATA_ADDRESS,
    output logic        oDATA_WRITE,
    output logic [31:0] oDATA_WRITE_DATA,
    input  logic        iDATA_WAIT_REQUEST,
    output logic        oIRQ,
    input  logic        iDIN,
    output logic        oDOUT
);

    localparam int unsigned PTR_W = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_PASS    = 3'd3,
        ST_FLUSH   = 3'd4
    } state_e;

    state_e      state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] high_q, low_q;
    logic [15:0] thresh_q, tmin_q, treset_q;
    logic [31:0] start_addr_q;
    logic [14:0] max_px_q, pixels_q;
    logic [4:0]  bit_cfg_q, bit_cnt_q;
    logic [30:0] shift_q;
    logic        overrun_q, partial_q, irq_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        wr_q;

    logic [31:0]      fifo_mem [pFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic        rise, fall, frame_end, is_idle, busy, csr_wr0;
    logic        bit_val, bit_take, push, push_ok, pop, fifo_full, fifo_empty;
    logic [31:0] shift_d, word_d;
    logic [14:0] pixels_d;

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    // Low time is only counted while low, so also require the line to still be low.
    assign frame_end = ~sync2_q && (low_q == treset_q);
    assign is_idle   = (state_q == ST_IDLE);
    assign busy      = ~is_idle;
    assign csr_wr0   = iCSR_WRITE && (iCSR_ADDRESS == 4'd0);

    assign bit_val   = (high_q > thresh_q);
    assign shift_d   = {shift_q, bit_val};
    assign word_d    = shift_d & ~(32'hFFFF_FFFE << bit_cfg_q);
    assign bit_take  = (state_q == ST_RECEIVE) && !frame_end && fall && (high_q >= tmin_q);
    assign push      = bit_take && (bit_cnt_q == bit_cfg_q);
    assign fifo_full  = (count_q == CNT_W'(pFIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop       = wr_q & ~iDATA_WAIT_REQUEST;
    assign push_ok   = push && (!fifo_full || pop);
    assign pixels_d  = pixels_q + 15'd1;

    assign oCSR_READ_DATA   = rdata_q;
    assign oDATA_ADDRESS    = addr_q;
    assign oDATA_WRITE      = wr_q;
    assign oDATA_WRITE_DATA = wdata_q;
    assign oIRQ             = irq_q;

    // Input synchronizer, edge history and pulse-width counters.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
        end else begin
            sync1_q <= iDIN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (rise)
                high_q <= '0;
            else if (sync2_q && high_q != 16'hFFFF)
                high_q <= high_q + 16'd1;
            if (fall)
                low_q <= '0;
            else if (!sync2_q && low_q != 16'hFFFF)
                low_q <= low_q + 16'd1;
        end
    end

    // Control FSM with CSR configuration and status flags.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_q      <= ST_IDLE;
            thresh_q     <= '0;
            tmin_q       <= '0;
            treset_q     <= '0;
            start_addr_q <= pSTART_ADDRESS;
            max_px_q     <= '0;
            bit_cfg_q    <= '0;
            pixels_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            overrun_q    <= 1'b0;
            partial_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            if (iCSR_WRITE && is_idle) begin
                case (iCSR_ADDRESS)
                    4'd1:    thresh_q     <= iCSR_WRITE_DATA[15:0];
                    4'd2:    tmin_q       <= iCSR_WRITE_DATA[15:0];
                    4'd3:    treset_q     <= iCSR_WRITE_DATA[15:0];
                    4'd4:    start_addr_q <= iCSR_WRITE_DATA;
                    default: ;
                endcase
            end
            if (csr_wr0) begin
                irq_q     <= 1'b0;
                overrun_q <= 1'b0;
                partial_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (csr_wr0) begin
                        max_px_q  <= iCSR_WRITE_DATA[30:16];
                        bit_cfg_q <= iCSR_WRITE_DATA[4:0];
                        if (iCSR_WRITE_DATA[31]) begin
                            state_q   <= ST_SYNC;
                            pixels_q  <= '0;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                ST_SYNC: begin
                    if (frame_end)
                        state_q <= ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    if (frame_end) begin
                        if (bit_cnt_q != '0)
                            partial_q <= 1'b1;
                        state_q <= ST_FLUSH;
                    end else if (bit_take) begin
                        shift_q <= shift_d[30:0];
                        if (push) begin
                            bit_cnt_q <= '0;
                            if (push_ok) begin
                                pixels_q <= pixels_d;
                                if (max_px_q != '0 && pixels_d == max_px_q)
                                    state_q <= ST_PASS;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_PASS: begin
                    if (frame_end)
                        state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fifo_empty && !wr_q) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pixel-word FIFO between decoder and write master.
    always_ff @(posedge iCLOCK) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= word_d;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (!push_ok && pop)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Avalon-MM write master: one outstanding write, address/data held until accepted.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            if (is_idle && csr_wr0 && iCSR_WRITE_DATA[31])
                addr_q <= start_addr_q;
            else if (pop)
                addr_q <= addr_q + 32'd4;
            if (!wr_q && !fifo_empty) begin
                wr_q    <= 1'b1;
                wdata_q <= fifo_mem[rd_ptr_q];
            end else if (pop) begin
                wr_q <= 1'b0;
            end
        end
    end

    // CSR read port, data valid the cycle after the strobe.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rdata_q <= '0;
        end else if (iCSR_READ) begin
            case (iCSR_ADDRESS)
                4'd0:    rdata_q <= {busy, pixels_q, 9'd0, partial_q, overrun_q, bit_cfg_q};
                4'd1:    rdata_q <= {16'd0, thresh_q};
                4'd2:    rdata_q <= {16'd0, tmin_q};
                4'd3:    rdata_q <= {16'd0, treset_q};
                4'd4:    rdata_q <= start_addr_q;
                4'd7:    rdata_q <= {29'd0, state_q};
                default: rdata_q <= '0;
            endcase
        end else begin
            rdata_q <= '0;
        end
    end

`ifdef NEOPIXEL_RX_FORWARD_EN
    logic dout_q;

    // Registering sync1 keeps the forwarded line aligned with the synchronized input.
    always_ff @(posedge iCLOCK) begin
        if (iRESET)
            dout_q <= 1'b0;
        else
            dout_q <= (state_q == ST_PASS) && sync1_q;
    end

    assign oDOUT = dout_q;
`else
    assign oDOUT = 1'b0;
`endif

endmodule

// File: tb/tb_neopixel_rx.sv
// Randomized self-checking bench for neopixel_rx: jittered bit timing, random pixels, reference model of expected writes.
module tb_neopixel_rx;

    localparam int unsigned DEPTH = 8;
    localparam int          GAP   = 2450;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  csr_addr;
    logic        csr_rd;
    logic [31:0] csr_rdata;
    logic        csr_wr;
    logic [31:0] csr_wdata;
    logic [31:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic        m_wait;
    logic        irq;
    logic        din;
    logic        dout;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wait_mode = 0;
    int          high_acc = 0;
    bit          count_high = 1'b0;
    int          dout_cnt = 0;
    int          dout_total = 0;
    int          exp_n;
    bit          exp_ovr;
    logic [31:0] pix[$];
    logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];

    neopixel_rx #(.pFIFO_DEPTH(DEPTH), .pSTART_ADDRESS(32'h0)) dut (
        .iCLOCK             (clk),
        .iRESET             (rst),
        .iCSR_ADDRESS       (csr_addr),
        .iCSR_READ          (csr_rd),
        .oCSR_READ_DATA     (csr_rdata),
        .iCSR_WRITE         (csr_wr),
        .iCSR_WRITE_DATA    (csr_wdata),
        .oDATA_ADDRESS      (m_addr),
        .oDATA_WRITE        (m_write),
        .oDATA_WRITE_DATA   (m_wdata),
        .iDATA_WAIT_REQUEST (m_wait),
        .oIRQ               (irq),
        .iDIN               (din),
        .oDOUT              (dout)
    );

    always #5 clk = ~clk;

    // Slave stall: 0 = never, 1 = always, 2 = random.
    initial begin
        m_wait = 1'b0;
        forever begin
            @(negedge clk);
            m_wait = (wait_mode == 2) ? 1'($urandom_range(1, 0)) : (wait_mode == 1);
        end
    end

    // Record accepted writes and forwarded-line activity.
    initial forever begin
        @(negedge clk);
        #1;
        if (m_write && !m_wait) begin
            got_a.push_back(m_addr);
            got_d.push_back(m_wdata);
        end
        if (dout) begin
            dout_cnt++;
            dout_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_wr = 1'b1;
        @(negedge clk);
        csr_wr = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        csr_addr = a; csr_rd = 1'b1;
        @(negedge clk);
        csr_rd = 1'b0;
        d = csr_rdata;
    endtask

    function automatic logic [31:0] mask_of(input logic [4:0] bc);
        return 32'((64'd1 << (int'(bc) + 1)) - 64'd1);
    endfunction

    // One bit with jittered timing inside the WS2812 tolerance window; optional short glitch in the low phase.
    task automatic send_bit(input bit b, input bit glitch);
        int h, l;
        h = b ? int'($urandom_range(42, 33)) : int'($urandom_range(20, 8));
        l = int'($urandom_range(24, 16));
        din = 1'b1; tick(h);
        din = 1'b0;
        if (glitch) begin
            tick(6); din = 1'b1; tick(3); din = 1'b0;
        end
        tick(l);
        if (count_high) high_acc += h;
    endtask

    task automatic send_pixel(input logic [31:0] v, input int nbits, input int glitch_at);
        for (int i = nbits - 1; i >= 0; i--) send_bit(v[i], i == glitch_at);
    endtask

    task automatic start_frame(input logic [14:0] mx, input logic [4:0] bc, input logic [31:0] base);
        din = 1'b1; tick(5); din = 1'b0;
        csr_write(4'd4, base);
        got_a.delete(); got_d.delete();
        dout_cnt = 0;
        csr_write(4'd0, {1'b1, mx, 11'd0, bc});
        tick(GAP);
    endtask

    // Reference model: which pixels land in memory, where, and whether any were dropped.
    task automatic build_expect(input logic [14:0] mx, input logic [4:0] bc, input logic [31:0] base, input int cap);
        int lim;
        lim = pix.size();
        if (mx != 0 && int'(mx) < lim) lim = int'(mx);
        exp_ovr = (lim > cap);
        if (lim > cap) lim = cap;
        exp_n = lim;
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < lim; i++) begin
            exp_a.push_back(base + 32'(4 * i));
            exp_d.push_back(pix[i] & mask_of(bc));
        end
    endtask

    task automatic wait_irq(input int budget);
        int k;
        k = 0;
        while (!irq && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("irq_seen", 32'(irq), 32'd1);
        check("writes_at_irq", 32'(got_a.size()), 32'(exp_a.size()));
    endtask

    task automatic finish_frame(input logic [4:0] bc, input bit partial);
        logic [31:0] r;
        wait_irq(400);
        check("wr_count", 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < got_a.size()) begin
                check($sformatf("wr_addr[%0d]", i), got_a[i], exp_a[i]);
                check($sformatf("wr_data[%0d]", i), got_d[i], exp_d[i]);
            end
        end
        csr_read(4'd0, r);
        check("status", r, {1'b0, 15'(exp_n), 9'd0, partial, exp_ovr, bc});
        csr_write(4'd0, {27'd0, bc});
        check("irq_clear", 32'(irq), 32'd0);
    endtask

    initial begin
        logic [31:0] r, base;
        logic [4:0]  bc;
        logic [14:0] mx;
        int          n;

        rst = 1'b1; din = 1'b0;
        csr_addr = '0; csr_rd = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
        tick(5);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_write", 32'(m_write), 32'd0);
        rst = 1'b0;
        tick(2);
        check("rst_addr", m_addr, 32'd0);
        check("rst_wdata", m_wdata, 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        csr_read(4'd0, r); check("rst_status", r, 32'd0);
        csr_read(4'd4, r); check("rst_start_addr", r, 32'd0);
        csr_read(4'd1, r); check("rst_thresh", r, 32'd0);

        csr_write(4'd1, 32'd28);
        csr_write(4'd2, 32'd5);
        csr_write(4'd3, 32'd2400);
        csr_read(4'd1, r); check("thresh_rb", r, 32'd28);
        csr_read(4'd2, r); check("tmin_rb", r, 32'd5);
        csr_read(4'd3, r); check("treset_rb", r, 32'd2400);
        csr_read(4'd5, r); check("unmapped", r, 32'd0);

        // Three known pixels, MAX=3.
        pix = '{32'h00FF00, 32'h123456, 32'hA5A5A5};
        build_expect(15'd3, 5'd23, 32'h1000, 1000);
        start_frame(15'd3, 5'd23, 32'h1000);
        foreach (pix[i]) send_pixel(pix[i], 24, -1);
        tick(GAP);
        finish_frame(5'd23, 1'b0);

        // Same pixels with a short glitch between bits of the middle pixel.
        build_expect(15'd3, 5'd23, 32'h1000, 1000);
        start_frame(15'd3, 5'd23, 32'h1000);
        send_pixel(pix[0], 24, -1);
        send_pixel(pix[1], 24, int'($urandom_range(23, 1)));
        send_pixel(pix[2], 24, -1);
        tick(GAP);
        finish_frame(5'd23, 1'b0);

        // Unlimited capture ending with a 10-bit fragment.
        pix = '{$urandom() & 32'hFF_FFFF};
        build_expect(15'd0, 5'd23, 32'h1800, 1000);
        start_frame(15'd0, 5'd23, 32'h1800);
        send_pixel(pix[0], 24, -1);
        send_pixel($urandom(), 10, -1);
        tick(GAP);
        finish_frame(5'd23, 1'b1);

        // Stalled slave through a 10-pixel frame: FIFO fills, later pixels dropped.
        pix.delete();
        for (int i = 0; i < 10; i++) pix.push_back($urandom() & 32'hFF_FFFF);
        build_expect(15'd0, 5'd23, 32'h2000, DEPTH);
        wait_mode = 1;
        start_frame(15'd0, 5'd23, 32'h2000);
        foreach (pix[i]) send_pixel(pix[i], 24, -1);
        tick(GAP);
        check("irq_while_stalled", 32'(irq), 32'd0);
        check("no_write_while_stalled", 32'(got_a.size()), 32'd0);
        csr_read(4'd0, r);
        check("status_stalled", r, {1'b1, 15'(exp_n), 9'd0, 1'b0, exp_ovr, 5'd23});
        wait_mode = 0;
        finish_frame(5'd23, 1'b0);

        // START issued mid-frame; a threshold write while busy must not stick.
        pix.delete();
        for (int i = 0; i < 3; i++) pix.push_back($urandom() & 32'hFF_FFFF);
        build_expect(15'd3, 5'd23, 32'h3000, 1000);
        csr_write(4'd4, 32'h3000);
        got_a.delete(); got_d.delete();
        fork
            begin
                send_pixel($urandom(), 24, -1);
                tick(GAP);
                foreach (pix[i]) send_pixel(pix[i], 24, -1);
                tick(GAP);
            end
            begin
                logic [31:0] rb;
                tick(300);
                csr_write(4'd0, {1'b1, 15'd3, 11'd0, 5'd23});
                tick(20);
                csr_write(4'd1, 32'd100);
                csr_read(4'd0, rb);
                check("busy_mid_frame", 32'(rb[31]), 32'd1);
            end
        join
        finish_frame(5'd23, 1'b0);
        csr_read(4'd1, r); check("thresh_locked", r, 32'd28);

        // MAX=2 with four pixels: the rest pass through.
        pix.delete();
        for (int i = 0; i < 4; i++) pix.push_back($urandom() & 32'hFF_FFFF);
        build_expect(15'd2, 5'd23, 32'h4000, 1000);
        start_frame(15'd2, 5'd23, 32'h4000);
        send_pixel(pix[0], 24, -1);
        send_pixel(pix[1], 24, -1);
        high_acc = 0; count_high = 1'b1;
        send_pixel(pix[2], 24, -1);
        send_pixel(pix[3], 24, -1);
        count_high = 1'b0;
        tick(GAP);
`ifdef NEOPIXEL_RX_FORWARD_EN
        check("dout_forwarded", 32'(dout_cnt), 32'(high_acc));
`else
        check("dout_quiet", 32'(dout_cnt), 32'd0);
`endif
        finish_frame(5'd23, 1'b0);

        // Random word widths, limits, base addresses and slave stalls.
        for (int it = 0; it < 2; it++) begin
            bc   = (it == 0) ? 5'd31 : 5'($urandom_range(30, 7));
            n    = int'($urandom_range(3, 1));
            mx   = 15'($urandom_range(n, 0));
            base = $urandom() & 32'hFFFF_FFFC;
            pix.delete();
            for (int i = 0; i < n; i++) pix.push_back($urandom() & mask_of(bc));
            build_expect(mx, bc, base, 1000);
            wait_mode = 2;
            start_frame(mx, bc, base);
            foreach (pix[i]) send_pixel(pix[i], int'(bc) + 1, -1);
            tick(GAP);
            finish_frame(bc, 1'b0);
            wait_mode = 0;
        end

`ifndef NEOPIXEL_RX_FORWARD_EN
        check("dout_never_high", 32'(dout_total), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
